inst_queue: RTL and testbench

Instruction queue between the fetch stage and the decode/dispatch stage. It accepts one fetched instruction and its PC per cycle from fetch, buffers them in program order in a circular FIFO, and presents the oldest entry to decode in show-ahead form. It back-pressures fetch with a registered full flag that leaves headroom for instructions already in flight, and it discards all contents when the ROB redirects the PC.

---
 rtl/inst_queue_pkg.sv | 11 +
 rtl/inst_queue.sv | 91 +++++++++
 tb/tb_inst_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and boolean constants used by the fetch/decode boundary.
// Queue-specific sizing stays local to inst_queue.
package inst_queue_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular show-ahead FIFO of {inst, pc}
// with a registered early-full flag for fetch and a whole-queue flush on ROB redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rdy_inst_if_in,
  input  logic [INST_WIDTH-1:0] inst_if_in,
  input  logic [ADDR_WIDTH-1:0] pc_if_in,
  output logic                  iq_full_if_out,
  output logic                  rdy_inst_dec_out,
  output logic [INST_WIDTH-1:0] inst_dec_out,
  output logic [ADDR_WIDTH-1:0] pc_dec_out,
  input  logic                  take_dec_in,
  input  logic                  refresh_rob_cdb_in,
  output logic                  overflow_out
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INST_WIDTH + ADDR_WIDTH;

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH - FULL_MARGIN);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic do_flush;
  logic do_enq;
  logic do_deq;
  logic write_at_full;

  // The full check uses the current count, so a slot freed this cycle is only reusable next cycle.
  always_comb begin
    do_flush      = rdy_in && refresh_rob_cdb_in;
    do_enq        = rdy_in && rdy_inst_if_in && !refresh_rob_cdb_in && (count < DEPTH_CNT);
    do_deq        = rdy_in && take_dec_in && !refresh_rob_cdb_in && (count != '0);
    write_at_full = rdy_in && rdy_inst_if_in && !refresh_rob_cdb_in && (count == DEPTH_CNT);

    count_next = count;
    if (do_flush) begin
      count_next = '0;
    end else if (do_enq && !do_deq) begin
      count_next = count + CNT_W'(1);
    end else if (do_deq && !do_enq) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      iq_full_if_out <= FALSE;
      overflow_out   <= FALSE;
    end else if (rdy_in) begin
      count          <= count_next;
      iq_full_if_out <= (count_next >= FULL_LEVEL);
      if (do_flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (do_enq) tail <= tail + PTR_W'(1);
        if (do_deq) head <= head + PTR_W'(1);
      end
      if (write_at_full) overflow_out <= TRUE;
    end
  end

  // Storage is deliberately not reset; the valid flag alone qualifies the head.
  always_ff @(posedge clk_in) begin
    if (do_enq) mem[tail] <= {inst_if_in, pc_if_in};
  end

  always_comb begin
    rdy_inst_dec_out             = (count != '0);
    {inst_dec_out, pc_dec_out}   = mem[head];
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a random phase,
// compared against a queue-based reference model of the FIFO's behaviour.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH       = 16;
  localparam int FULL_MARGIN = 2;

  logic                  clk_in;
  logic                  rst_in;
  logic                  rdy_in;
  logic                  rdy_inst_if_in;
  logic [INST_WIDTH-1:0] inst_if_in;
  logic [ADDR_WIDTH-1:0] pc_if_in;
  logic                  iq_full_if_out;
  logic                  rdy_inst_dec_out;
  logic [INST_WIDTH-1:0] inst_dec_out;
  logic [ADDR_WIDTH-1:0] pc_dec_out;
  logic                  take_dec_in;
  logic                  refresh_rob_cdb_in;
  logic                  overflow_out;

  inst_queue #(.DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .rdy_inst_if_in     (rdy_inst_if_in),
    .inst_if_in         (inst_if_in),
    .pc_if_in           (pc_if_in),
    .iq_full_if_out     (iq_full_if_out),
    .rdy_inst_dec_out   (rdy_inst_dec_out),
    .inst_dec_out       (inst_dec_out),
    .pc_dec_out         (pc_dec_out),
    .take_dec_in        (take_dec_in),
    .refresh_rob_cdb_in (refresh_rob_cdb_in),
    .overflow_out       (overflow_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference model: program-order list of {inst, pc}, plus the two flags.
  logic [63:0] model_q[$];
  logic        model_full;
  logic        model_ovf;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check_eq({tag, ".valid"}, 64'(rdy_inst_dec_out), 64'(model_q.size() != 0));
    check_eq({tag, ".full"}, 64'(iq_full_if_out), 64'(model_full));
    check_eq({tag, ".ovf"}, 64'(overflow_out), 64'(model_ovf));
    check_eq({tag, ".count"}, 64'(dut.count), 64'(model_q.size()));
    if (model_q.size() != 0) begin
      check_eq({tag, ".inst"}, 64'(inst_dec_out), 64'(model_q[0][63:32]));
      check_eq({tag, ".pc"}, 64'(pc_dec_out), 64'(model_q[0][31:0]));
    end
  endtask

  // Drives one cycle of inputs, advances the model, and checks just after the edge.
  task automatic applyStimulus(input string tag, input logic rdy, input logic wr,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic take, input logic flush);
    int  n;
    bit  can_wr;
    bit  can_rd;
    rdy_in             = rdy;
    rdy_inst_if_in     = wr;
    inst_if_in         = inst;
    pc_if_in           = pc;
    take_dec_in        = take;
    refresh_rob_cdb_in = flush;
    n = model_q.size();
    if (rdy) begin
      if (flush) begin
        model_q.delete();
      end else begin
        can_wr = wr && (n < DEPTH);
        can_rd = take && (n != 0);
        if (wr && n == DEPTH) model_ovf = 1'b1;
        if (can_rd) void'(model_q.pop_front());
        if (can_wr) model_q.push_back({inst, pc});
      end
      model_full = (model_q.size() >= DEPTH - FULL_MARGIN);
    end
    @(posedge clk_in);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle_inputs();
    rdy_in             = 1'b1;
    rdy_inst_if_in     = 1'b0;
    inst_if_in         = '0;
    pc_if_in           = '0;
    take_dec_in        = 1'b0;
    refresh_rob_cdb_in = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_full = 1'b0;
    model_ovf  = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    idle_inputs();
    model_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkOutput("reset");

    // First write becomes visible one cycle later.
    applyStimulus("first_wr", 1, 1, 32'h0000_0013, 32'h0, 0, 0);
    applyStimulus("first_take", 1, 0, 0, 0, 1, 0);
    applyStimulus("take_empty", 1, 0, 0, 0, 1, 0);

    // Fill to capacity, then one more write that must be dropped.
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus("fill", 1, 1, 32'hA000_0000 + 32'(i), 32'(i * 4), 0, 0);
    // Take plus write at full: write still dropped.
    applyStimulus("full_both", 1, 1, 32'hDEAD_BEEF, 32'h1234, 1, 0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("drain", 1, 0, 0, 0, 1, 0);

    // Streaming write+take across pointer wrap.
    for (int i = 0; i < 40; i++)
      applyStimulus("stream", 1, 1, 32'hB000_0000 + 32'(i), 32'(i * 4), 1, 0);
    applyStimulus("stream_end", 1, 0, 0, 0, 1, 0);

    // Flush with a concurrent write and take.
    for (int i = 0; i < 5; i++)
      applyStimulus("pre_flush", 1, 1, 32'hC000_0000 + 32'(i), 32'h100 + 32'(i * 4), 0, 0);
    applyStimulus("flush", 1, 1, 32'hC0DE_0000, 32'h200, 1, 1);
    applyStimulus("post_flush", 1, 0, 0, 0, 0, 0);

    // Global enable low freezes everything.
    for (int i = 0; i < 4; i++)
      applyStimulus("pre_stall", 1, 1, 32'hD000_0000 + 32'(i), 32'h300 + 32'(i * 4), 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall", 0, 1, 32'hEEEE_0000, 32'h400, 1, 1);
    applyStimulus("resume", 1, 1, 32'hD000_0004, 32'h310, 1, 0);
    applyStimulus("resume2", 1, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-fill, checked before the next edge.
    applyStimulus("pre_rst_flush", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      applyStimulus("pre_rst", 1, 1, 32'hF000_0000 + 32'(i), 32'h500 + 32'(i * 4), 0, 0);
    idle_inputs();
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    checkOutput("async_rst");
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      applyStimulus("rand", (r[3:0] != 0), r[4] | r[5], $urandom, $urandom,
                    r[6], (r[11:7] == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
